// File: rtl/light_pwm_driver_pkg.sv
// Shared encodings for the light-mode interface and the brightness ramp FSM.
// The light FSM imports the same mode encodings as this driver.
package light_pwm_driver_pkg;

   typedef enum logic [1:0] {
      LIGHT_OFF  = 2'b00,
      LIGHT_LOW  = 2'b01,
      LIGHT_MID  = 2'b10,
      LIGHT_HIGH = 2'b11
   } light_mode_t;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      UP   = 2'b01,
      DOWN = 2'b10
   } ramp_state_t;

   // Counter width able to hold 0..n-1, never narrower than one bit.
   function automatic int cnt_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/light_pwm_driver_pwm_gen.sv
// PWM generator: period of 2^PWM_BITS-1 clocks, duty re-latched only at the
// period boundary so a level change never cuts a period short or stretches it.
module light_pwm_driver_pwm_gen #(
   parameter int PWM_BITS = 8
) (
   input  logic                i_clk,
   input  logic                i_reset,
   input  logic [PWM_BITS-1:0] i_duty,
   output logic                o_led
);

   localparam int CNT_MAX_I = (1 << PWM_BITS) - 2;
   localparam logic [PWM_BITS-1:0] CNT_MAX = PWM_BITS'(CNT_MAX_I);

   logic [PWM_BITS-1:0] cnt_q, cnt_d;
   logic [PWM_BITS-1:0] duty_q, duty_d;
   logic                led_q, led_d;

   // The compare uses next-cycle values so o_led lines up with the counter.
   always_comb begin
      cnt_d  = cnt_q + 1'b1;
      duty_d = duty_q;
      if (cnt_q == CNT_MAX) begin
         cnt_d  = '0;
         duty_d = i_duty;
      end
      led_d = (cnt_d < duty_d);
   end

   always_ff @(posedge i_clk) begin
      if (!i_reset) begin
         cnt_q  <= '0;
         duty_q <= '0;
         led_q  <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         duty_q <= duty_d;
         led_q  <= led_d;
      end
   end

   assign o_led = led_q;

endmodule

// File: rtl/light_pwm_driver.sv
// Drives the board LED from the 2-bit light mode, fading one duty step per
// tick toward the level of the current mode.
module light_pwm_driver
   import light_pwm_driver_pkg::*;
#(
   parameter int PWM_BITS = 8,
   parameter int STEP_DIV = 100000,
   parameter int LVL_LOW  = 64,
   parameter int LVL_MID  = 128,
   parameter int LVL_HIGH = 255
) (
   input  logic                i_clk,
   input  logic                i_reset,
   input  logic [1:0]          i_light,
   output logic                o_led,
   output logic [PWM_BITS-1:0] o_level,
   output logic                o_busy
);

   localparam int SW = cnt_width(STEP_DIV);
   localparam logic [SW-1:0] STEP_LAST = SW'(STEP_DIV - 1);

   logic [SW-1:0]       step_cnt_q, step_cnt_d;
   logic                tick;
   logic [PWM_BITS-1:0] target;
   logic [PWM_BITS-1:0] level_q, level_d;
   ramp_state_t         state_q, state_d;
   logic                busy_q, busy_d;

   always_comb begin
      target = '0;
      case (light_mode_t'(i_light))
         LIGHT_OFF:  target = '0;
         LIGHT_LOW:  target = PWM_BITS'(LVL_LOW);
         LIGHT_MID:  target = PWM_BITS'(LVL_MID);
         LIGHT_HIGH: target = PWM_BITS'(LVL_HIGH);
         default:    target = '0;
      endcase
   end

   always_comb begin
      tick       = (step_cnt_q == STEP_LAST);
      step_cnt_d = tick ? '0 : step_cnt_q + 1'b1;
   end

   // Steps are gated by the live target as well as the state, so a target
   // that moved this cycle can never receive a stale step.
   always_comb begin
      level_d = level_q;
      if (tick) begin
         if (state_q == UP && level_q < target) begin
            level_d = level_q + 1'b1;
         end else if (state_q == DOWN && level_q > target) begin
            level_d = level_q - 1'b1;
         end
      end
      state_d = IDLE;
      if (level_d < target) begin
         state_d = UP;
      end else if (level_d > target) begin
         state_d = DOWN;
      end
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge i_clk) begin
      if (!i_reset) begin
         step_cnt_q <= '0;
         level_q    <= '0;
         state_q    <= IDLE;
         busy_q     <= 1'b0;
      end else begin
         step_cnt_q <= step_cnt_d;
         level_q    <= level_d;
         state_q    <= state_d;
         busy_q     <= busy_d;
      end
   end

   light_pwm_driver_pwm_gen #(
      .PWM_BITS(PWM_BITS)
   ) u_pwm_gen (
      .i_clk  (i_clk),
      .i_reset(i_reset),
      .i_duty (level_q),
      .o_led  (o_led)
   );

   assign o_level = level_q;
   assign o_busy  = busy_q;

endmodule

// File: tb/tb_light_pwm_driver.sv
// Directed bench for light_pwm_driver with a 4-bit PWM (period 15) and a
// ramp tick every 2 clocks.
module tb_light_pwm_driver;

   logic       clk = 1'b0;
   logic       i_reset = 1'b0;
   logic [1:0] i_light = 2'b11;
   logic       o_led;
   logic [3:0] o_level;
   logic       o_busy;

   int checks = 0;
   int failures = 0;

   typedef struct {
      logic [1:0] light;
      int         exp_level;
      int         exp_highs;
   } vec_t;

   vec_t vecs[6];

   light_pwm_driver #(
      .PWM_BITS(4),
      .STEP_DIV(2),
      .LVL_LOW (4),
      .LVL_MID (8),
      .LVL_HIGH(15)
   ) dut (
      .i_clk  (clk),
      .i_reset(i_reset),
      .i_light(i_light),
      .o_led  (o_led),
      .o_level(o_level),
      .o_busy (o_busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   task automatic tick_clk();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_idle(input int bound, input string name);
      int n = 0;
      do begin
         tick_clk();
         n++;
      end while (o_busy && n < bound);
      check(name, int'(o_busy), 0);
   endtask

   task automatic wait_level(input int lvl, input int bound, input string name);
      int n = 0;
      while (int'(o_level) != lvl && n < bound) begin
         tick_clk();
         n++;
      end
      check(name, int'(o_level), lvl);
   endtask

   task automatic count_highs(input int n, output int h);
      h = 0;
      for (int i = 0; i < n; i++) begin
         tick_clk();
         h += int'(o_led);
      end
   endtask

   initial begin
      int highs, prev, nchg, last_t, maxlvl, exp_lvl;
      logic prev_led, found;

      vecs[0] = '{2'b00, 0, 0};
      vecs[1] = '{2'b10, 8, 8};
      vecs[2] = '{2'b11, 15, 15};
      vecs[3] = '{2'b01, 4, 4};
      vecs[4] = '{2'b10, 8, 8};
      vecs[5] = '{2'b00, 0, 0};

      // Reset held three cycles with the highest mode requested
      for (int i = 0; i < 3; i++) begin
         tick_clk();
         check("rst_led", int'(o_led), 0);
         check("rst_level", int'(o_level), 0);
         check("rst_busy", int'(o_busy), 0);
      end
      $display("reset held 3 cycles level=%0d busy=%0d", o_level, o_busy);

      // Ramp 0 -> 15: one step every second clock after the release edge
      i_reset = 1'b1;
      for (int k = 0; k < 40; k++) begin
         tick_clk();
         exp_lvl = ((k + 1) / 2 > 15) ? 15 : (k + 1) / 2;
         check("up_level", int'(o_level), exp_lvl);
         check("up_busy", int'(o_busy), (exp_lvl != 15) ? 1 : 0);
      end
      $display("ramp to high level=%0d busy=%0d", o_level, o_busy);
      count_highs(15, highs);
      count_highs(30, highs);
      check("full_on", highs, 30);
      $display("full duty highs=%0d of 30", highs);

      // Settled level and per-period high count for each mode
      for (int v = 0; v < 6; v++) begin
         i_light = vecs[v].light;
         tick_clk();
         check("vec_busy_rise", int'(o_busy), 1);
         wait_idle(100, "vec_settle");
         check("vec_level", int'(o_level), vecs[v].exp_level);
         count_highs(20, highs);
         count_highs(15, highs);
         check("vec_highs", highs, vecs[v].exp_highs);
         $display("vec %0d light=%b level=%0d highs=%0d", v, vecs[v].light, o_level, highs);
      end

      // Low mode from 0: values 1,2,3,4 exactly two clocks apart
      i_light = 2'b01;
      prev = 0;
      nchg = 0;
      last_t = -1;
      for (int t = 0; t < 12; t++) begin
         tick_clk();
         if (t == 0) check("low_busy_rise", int'(o_busy), 1);
         if (int'(o_level) != prev) begin
            nchg++;
            check("low_step_val", int'(o_level), nchg);
            if (nchg > 1) check("low_step_gap", t - last_t, 2);
            last_t = t;
            prev = int'(o_level);
         end
      end
      check("low_steps", nchg, 4);
      check("low_final", int'(o_level), 4);
      check("low_idle", int'(o_busy), 0);
      $display("low ramp steps=%0d level=%0d", nchg, o_level);

      // Mid-period change at cnt 7: current period keeps 4 highs
      count_highs(20, highs);
      prev_led = o_led;
      found = 1'b0;
      for (int i = 0; i < 40 && !found; i++) begin
         tick_clk();
         if (!prev_led && o_led) found = 1'b1;
         prev_led = o_led;
      end
      check("period_found", int'(found), 1);
      highs = int'(o_led);
      for (int c = 1; c <= 7; c++) begin
         tick_clk();
         highs += int'(o_led);
      end
      i_light = 2'b10;
      for (int c = 8; c <= 14; c++) begin
         tick_clk();
         highs += int'(o_led);
      end
      check("glitch_cur", highs, 4);
      count_highs(15, highs);
      check("glitch_next", highs, 7);
      count_highs(15, highs);
      check("glitch_after", highs, 8);
      $display("mid-period change highs next=%0d level=%0d", highs, o_level);

      // Reversal at level 6 while ramping toward 15
      i_light = 2'b00;
      wait_idle(100, "rev_clear");
      i_light = 2'b11;
      wait_level(6, 60, "rev_reach6");
      i_light = 2'b01;
      prev = 6;
      maxlvl = 6;
      nchg = 0;
      for (int i = 0; i < 30; i++) begin
         tick_clk();
         if (int'(o_level) > maxlvl) maxlvl = int'(o_level);
         if (int'(o_level) != prev) begin
            nchg++;
            check("rev_val", int'(o_level), 6 - nchg);
            prev = int'(o_level);
         end
         if (!o_busy) break;
      end
      check("rev_max", maxlvl, 6);
      check("rev_steps", nchg, 2);
      check("rev_final", int'(o_level), 4);
      check("rev_idle", int'(o_busy), 0);
      $display("reversal max=%0d level=%0d busy=%0d", maxlvl, o_level, o_busy);

      // Reset mid-ramp at level 9, then ramp to mid from 0
      i_light = 2'b11;
      wait_level(9, 60, "mrst_reach9");
      i_reset = 1'b0;
      tick_clk();
      check("mrst_level", int'(o_level), 0);
      check("mrst_led", int'(o_led), 0);
      check("mrst_busy", int'(o_busy), 0);
      tick_clk();
      i_light = 2'b10;
      i_reset = 1'b1;
      tick_clk();
      check("mrst_rel_level", int'(o_level), 0);
      check("mrst_rel_busy", int'(o_busy), 1);
      prev = 0;
      nchg = 0;
      for (int i = 0; i < 40 && o_busy; i++) begin
         tick_clk();
         if (int'(o_level) != prev) begin
            nchg++;
            check("mrst_val", int'(o_level), nchg);
            prev = int'(o_level);
         end
      end
      check("mrst_steps", nchg, 8);
      check("mrst_final", int'(o_level), 8);
      check("mrst_idle", int'(o_busy), 0);
      $display("reset mid-ramp restart level=%0d steps=%0d", o_level, nchg);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
